mips_boot_debug_ctrl: RTL
=========================

// Module: mips_boot_debug_ctrl
// PURPOSE
//  Parametrised boot/run/dump sequencer for the MIPS processor top.
//  Streams a program into instruction memory, holds then releases the PC and counts cycles.
//  Stops on a halt word or a cycle limit, then dumps the register file over a valid/ready port.
//  Sits between the bench/host and the processor's memory-address and PC-control muxes.
// PARAMETERS
//  DATA_W      32            instruction/data word width
//  PROG_DEPTH  256           max program words loadable
//  LOAD_W      8             width of load counter; 2**LOAD_W >= PROG_DEPTH
//  REG_COUNT   32            registers dumped
//  REG_AW      5             register address width
//  CYC_W       16            cycle counter width
//  MAX_CYCLES  16'd1000      run-cycle limit (timeout)
//  HALT_WORD   32'h0000000C  instruction value that ends RUN (syscall)
// PORTS
//  clk         in   1        clock, rising edge
//  resetN      in   1        asynchronous reset, active low
//  progValid   in   1        program word offered
//  progReady   out  1        program word accepted when valid&ready
//  progData    in   DATA_W   program word
//  progLast    in   1        final program word
//  pcValue     in   DATA_W   current PC from program_counter
//  instruction in   DATA_W   instruction memory read data
//  imemAddr    out  DATA_W   instr mem address: loadCount*4 in LOAD, else pcValue
//  imemData    out  DATA_W   = progData
//  imemWrite   out  1        = progValid&progReady
//  imemRead    out  1        1 in RUN only
//  pcReset     out  1        PC held at 0
//  pcWrite     out  1        PC update enable
//  rerun       in   1        in DONE: rerun loaded program
//  cycleNo     out  CYC_W    RUN cycles elapsed
//  timeout     out  1        run ended by MAX_CYCLES
//  dbgSel      out  1        processor reg-file read-address mux select
//  dbgRegAddr  out  REG_AW   debug register address
//  dbgRegData  in   DATA_W   reg-file read data (combinational)
//  dumpValid   out  1        dump word valid
//  dumpReady   in   1        dump word consumed when valid&ready
//  dumpIdx     out  REG_AW   index of dump word
//  dumpData    out  DATA_W   dump word
//  done        out  1        sequence complete
// BEHAVIOUR
//  Reset (async, resetN=0): state LOAD, loadCount=0, progReady=0, pcReset=1,
//   pcWrite=0, imemRead=0, cycleNo=0, timeout=0, dbgSel=0, dumpValid=0, dumpIdx=0, dumpData=0, done=0.
//   Reset honoured in any state, including mid-load, mid-run and mid-dump; imem contents are not cleared.
//  FSM: LOAD -> PCRST -> RUN -> DA -> DD -> ... -> DONE.
//   LOAD:
//    - progReady=1, pcReset=1.
//    - Each accepted word writes imem at loadCount*4, then loadCount++.
//    - Accepting a word with progLast=1, or word index PROG_DEPTH-1, -> PCRST.
//    - Words beyond PROG_DEPTH are never accepted.
//   PCRST: one cycle; pcReset=1, cycleNo cleared -> RUN.
//   RUN:
//    - pcReset=0, pcWrite=1, imemRead=1, cycleNo++ each edge.
//    - Exit to DA when instruction==HALT_WORD (timeout=0).
//    - Exit to DA when cycleNo==MAX_CYCLES-1 (timeout=1).
//    - Halt has priority on the same cycle.
//   DA (address): dbgSel=1, dbgRegAddr=dumpIdx; next edge captures dbgRegData into dumpData, -> DD.
//   DD (data):
//    - dumpValid=1; dumpData and dumpIdx held stable until dumpReady.
//    - On valid&ready: if dumpIdx==REG_COUNT-1 -> DONE, else dumpIdx++ -> DA.
//    - Each register costs >=2 cycles.
//   DONE: done=1, dbgSel=0, pcWrite=0.
//    - rerun=1 -> PCRST; clears timeout and dumpIdx; program kept.
//    - rerun ignored outside DONE.
//  cycleNo never wraps; it stops at MAX_CYCLES-1.
// CONFIGURATION
//  MIPS_DMEM_DUMP_EN defined:
//   - Adds params DMEM_WORDS (default 64) and outputs dmemDbgAddr[DATA_W], dmemDbgSel.
//   - Adds input dmemDbgData[DATA_W].
//   - After the last register: states MA/MD dump DMEM_WORDS words at addresses 4*k.
//   - dumpIdx resets to 0 for memory words; same handshake; then -> DONE.
//  Not defined: ports absent; register dump -> DONE directly.
// TESTING
//  - Load 2 words (h20100002, h22100003, last on 2nd):
//    imemWrite at addr 0,4; then pcReset=1 for exactly 1 cycle; then RUN with cycleNo=0,1,...
//  - PROG_DEPTH=4, 6 words offered, no progLast:
//    4 accepted; progReady=0 afterward; PCRST entered after the 4th.
//  - HALT_WORD presented at RUN cycle 5:
//    cycleNo freezes at 6; timeout=0; dbgSel=1 next cycle.
//  - MAX_CYCLES=8, no halt: exit after cycleNo=7; timeout=1.
//  - Dump with dbgRegData=idx*3 and dumpReady low 3 cycles at idx 2:
//    dumpData=6 held stable; 32 words idx 0..31 in order; then done=1.
//  - resetN low mid-dump (idx 10), then rerun from DONE:
//    all outputs return to reset values; rerun restarts at PCRST, program intact.

Source files
------------

// File: rtl/mips_boot_debug_ctrl.sv
// mips_boot_debug_ctrl
//   Boot/run/dump sequencer that sits between the host and the MIPS core.
//   It streams a program into instruction memory, holds and then releases the
//   PC, and counts run cycles. RUN ends on HALT_WORD or on the cycle limit.
//   The register file is then dumped one word at a time over a valid/ready port.
//
// Optional build macro: MIPS_DMEM_DUMP_EN
//   When defined, DMEM_WORDS data-memory words are dumped after the registers
//   (addresses 4*k). This adds the dmemDbgAddr/dmemDbgSel outputs and the
//   dmemDbgData input.
//
// Ports
//   clk, resetN                 clock (rising edge), async active-low reset
//   progValid/progReady/progData/progLast   program load handshake
//   pcValue, instruction        current PC and imem read data from the core
//   imemAddr/imemData/imemWrite/imemRead    instruction memory control
//   pcReset, pcWrite            PC control
//   rerun                       restart the loaded program from DONE
//   cycleNo, timeout            run cycle count, run ended by the cycle limit
//   dbgSel, dbgRegAddr, dbgRegData          reg-file debug read path
//   dumpValid/dumpReady/dumpIdx/dumpData    dump stream
//   done                        sequence complete
module mips_boot_debug_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                PROG_DEPTH = 256,
    parameter int                LOAD_W     = 8,
    parameter int                REG_COUNT  = 32,
    parameter int                REG_AW     = 5,
    parameter int                CYC_W      = 16,
    parameter logic [CYC_W-1:0]  MAX_CYCLES = 16'd1000,
    parameter logic [DATA_W-1:0] HALT_WORD  = 32'h0000000C
`ifdef MIPS_DMEM_DUMP_EN
    ,
    parameter int                DMEM_WORDS = 64
`endif
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              progValid,
    output logic              progReady,
    input  logic [DATA_W-1:0] progData,
    input  logic              progLast,
    input  logic [DATA_W-1:0] pcValue,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] imemAddr,
    output logic [DATA_W-1:0] imemData,
    output logic              imemWrite,
    output logic              imemRead,
    output logic              pcReset,
    output logic              pcWrite,
    input  logic              rerun,
    output logic [CYC_W-1:0]  cycleNo,
    output logic              timeout,
    output logic              dbgSel,
    output logic [REG_AW-1:0] dbgRegAddr,
    input  logic [DATA_W-1:0] dbgRegData,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [REG_AW-1:0] dumpIdx,
    output logic [DATA_W-1:0] dumpData,
`ifdef MIPS_DMEM_DUMP_EN
    output logic [DATA_W-1:0] dmemDbgAddr,
    output logic              dmemDbgSel,
    input  logic [DATA_W-1:0] dmemDbgData,
`endif
    output logic              done
);

    // The dump index must also cover data-memory words when that dump is built in.
`ifdef MIPS_DMEM_DUMP_EN
    localparam int IDX_W = (REG_AW > $clog2(DMEM_WORDS)) ? REG_AW : $clog2(DMEM_WORDS);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(DMEM_WORDS - 1);
`else
    localparam int IDX_W = REG_AW;
`endif
    localparam logic [IDX_W-1:0]  REG_LAST  = IDX_W'(REG_COUNT - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(PROG_DEPTH - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = MAX_CYCLES - CYC_W'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_PCRST = 3'd1,
        S_RUN   = 3'd2,
        S_DA    = 3'd3,
        S_DD    = 3'd4,
        S_DONE  = 3'd5,
        S_MA    = 3'd6,
        S_MD    = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic                prog_ready_q, pc_reset_q, pc_write_q, imem_read_q;
    logic                dbg_sel_q, dump_valid_q, done_q, dmem_sel_q;
    logic                prog_accept_s;

    assign prog_accept_s = progValid & prog_ready_q;

    // Next-state and datapath update for the boot/run/dump sequence.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        case (state_q)
            S_LOAD: begin
                if (prog_accept_s) begin
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                    if (progLast || (load_cnt_q == LOAD_LAST)) begin
                        state_d = S_PCRST;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_PCRST: begin
                cyc_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Saturate so the count never wraps past the limit.
                if (cyc_q != CYC_LAST) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else begin
                    cyc_d = cyc_q;
                end
                // A halt word seen on the limit cycle is still a clean halt.
                if (instruction == HALT_WORD) begin
                    state_d   = S_DA;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                end else if (cyc_q == CYC_LAST) begin
                    state_d   = S_DA;
                    timeout_d = 1'b1;
                    idx_d     = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DA: begin
                dump_data_d = dbgRegData;
                state_d     = S_DD;
            end
            S_DD: begin
                if (dumpReady) begin
                    if (idx_q == REG_LAST) begin
`ifdef MIPS_DMEM_DUMP_EN
                        idx_d   = '0;
                        state_d = S_MA;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_DA;
                    end
                end else begin
                    state_d = S_DD;
                end
            end
`ifdef MIPS_DMEM_DUMP_EN
            S_MA: begin
                dump_data_d = dmemDbgData;
                state_d     = S_MD;
            end
            S_MD: begin
                if (dumpReady) begin
                    if (idx_q == MEM_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_MA;
                    end
                end else begin
                    state_d = S_MD;
                end
            end
`endif
            S_DONE: begin
                if (rerun) begin
                    state_d   = S_PCRST;
                    timeout_d = 1'b0;
                    idx_d     = '0;
                    cyc_d     = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, counters and registered control outputs. The outputs are decoded
    // from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_LOAD;
            load_cnt_q   <= '0;
            cyc_q        <= '0;
            timeout_q    <= 1'b0;
            idx_q        <= '0;
            dump_data_q  <= '0;
            prog_ready_q <= 1'b0;
            pc_reset_q   <= 1'b1;
            pc_write_q   <= 1'b0;
            imem_read_q  <= 1'b0;
            dbg_sel_q    <= 1'b0;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b0;
            dmem_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            cyc_q        <= cyc_d;
            timeout_q    <= timeout_d;
            idx_q        <= idx_d;
            dump_data_q  <= dump_data_d;
            prog_ready_q <= (state_d == S_LOAD);
            pc_reset_q   <= (state_d == S_LOAD) || (state_d == S_PCRST);
            pc_write_q   <= (state_d == S_RUN);
            imem_read_q  <= (state_d == S_RUN);
            dbg_sel_q    <= (state_d == S_DA) || (state_d == S_DD);
            dump_valid_q <= (state_d == S_DD) || (state_d == S_MD);
            done_q       <= (state_d == S_DONE);
            dmem_sel_q   <= (state_d == S_MA) || (state_d == S_MD);
        end
    end

    assign progReady  = prog_ready_q;
    assign imemData   = progData;
    assign imemWrite  = prog_accept_s;
    assign imemAddr   = (state_q == S_LOAD) ? DATA_W'({load_cnt_q, 2'b00}) : pcValue;
    assign imemRead   = imem_read_q;
    assign pcReset    = pc_reset_q;
    assign pcWrite    = pc_write_q;
    assign cycleNo    = cyc_q;
    assign timeout    = timeout_q;
    assign dbgSel     = dbg_sel_q;
    assign dbgRegAddr = idx_q[REG_AW-1:0];
    assign dumpValid  = dump_valid_q;
    assign dumpIdx    = idx_q[REG_AW-1:0];
    assign dumpData   = dump_data_q;
    assign done       = done_q;
`ifdef MIPS_DMEM_DUMP_EN
    assign dmemDbgAddr = DATA_W'({idx_q, 2'b00});
    assign dmemDbgSel  = dmem_sel_q;
`else
    // Data-memory select only exists when the memory dump is built in.
    logic unused_dmem_sel_s;
    assign unused_dmem_sel_s = dmem_sel_q;
`endif

endmodule
